// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA rectangle-fill arbiter.
//   SCREEN_W / SCREEN_H : visible raster size; anything at or beyond is clipped
//   COLOUR_BITS         : adapter colour width (3 bits per channel)
//   colour_t, x_t, y_t  : pixel colour and screen coordinate types
//   fill_state_t        : rectangle engine FSM states
package vga_pkg;

   localparam int SCREEN_W    = 160;
   localparam int SCREEN_H    = 120;
   localparam int COLOUR_BITS = 9;

   typedef logic [COLOUR_BITS-1:0] colour_t;
   typedef logic [7:0]             x_t;
   typedef logic [6:0]             y_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fill_state_t;

endpackage

// File: rtl/vga_rect_walker.sv
// vga_rect_walker: rectangle-fill engine. Latches a rectangle on fill_start,
// walks it in raster order and presents one pixel at a time as a valid/ready
// stream (pix_valid is high for the whole RUN state; pix_ready is the engine
// grant). Pixels outside the screen are flagged with pix_visible=0; they still
// take a grant so the fill duration does not depend on clipping.
//
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   fill_start, fill_x0/y0/w/h/colour : fill launch pulse and rectangle
//   fill_abort                : (VGA_FILL_ABORT_EN only) stop the fill early
//   pix_ready                 : engine grant from the arbiter
//   pix_valid, pix_visible    : engine request, current pixel on screen
//   pix_x, pix_y, pix_colour  : current pixel
//   fill_busy, fill_done      : RUN indicator, one-cycle completion pulse
//
// Optional feature macro: VGA_FILL_ABORT_EN adds the fill_abort input.
module vga_rect_walker
   import vga_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fill_start,
   input  logic [7:0]             fill_x0,
   input  logic [6:0]             fill_y0,
   input  logic [7:0]             fill_w,
   input  logic [6:0]             fill_h,
   input  logic [COLOUR_BITS-1:0] fill_colour,
`ifdef VGA_FILL_ABORT_EN
   input  logic                   fill_abort,
`endif
   input  logic                   pix_ready,
   output logic                   pix_valid,
   output logic                   pix_visible,
   output logic [7:0]             pix_x,
   output logic [6:0]             pix_y,
   output logic [COLOUR_BITS-1:0] pix_colour,
   output logic                   fill_busy,
   output logic                   fill_done
);

   fill_state_t state_q, state_d;

   // Counters are one bit wider than the coordinates so x0+w-1 / y0+h-1
   // never wrap; anything past the screen edge is simply clipped.
   logic [8:0]    cx_q, cx_d;
   logic [7:0]    cy_q, cy_d;
   logic [8:0]    x_last_q, x_last_d;
   logic [7:0]    y_last_q, y_last_d;
   logic [7:0]    x0_q, x0_d;
   colour_t       colour_q, colour_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cx_q     <= '0;
         cy_q     <= '0;
         x_last_q <= '0;
         y_last_q <= '0;
         x0_q     <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         x_last_q <= x_last_d;
         y_last_q <= y_last_d;
         x0_q     <= x0_d;
         colour_q <= colour_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      x_last_d = x_last_q;
      y_last_d = y_last_q;
      x0_d     = x0_q;
      colour_d = colour_q;
      case (state_q)
         IDLE: begin
            if (fill_start) begin
               x0_d     = fill_x0;
               colour_d = fill_colour;
               cx_d     = {1'b0, fill_x0};
               cy_d     = {1'b0, fill_y0};
               x_last_d = {1'b0, fill_x0} + {1'b0, fill_w} - 9'd1;
               y_last_d = {1'b0, fill_y0} + {1'b0, fill_h} - 8'd1;
               if (fill_w == 8'd0 || fill_h == 7'd0) state_d = DONE;
               else                                  state_d = RUN;
            end
         end
         RUN: begin
            if (pix_ready) begin
               if (cx_q == x_last_q) begin
                  cx_d = {1'b0, x0_q};
                  if (cy_q == y_last_q) state_d = DONE;
                  else                  cy_d = cy_q + 8'd1;
               end else begin
                  cx_d = cx_q + 9'd1;
               end
            end
`ifdef VGA_FILL_ABORT_EN
            // The grant this cycle (if any) has already been taken by the
            // arbiter, so that pixel is still plotted.
            if (fill_abort) state_d = DONE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pix_valid   = (state_q == RUN);
   assign pix_visible = (cx_q < 9'(SCREEN_W)) && (cy_q < 8'(SCREEN_H));
   assign pix_x       = cx_q[7:0];
   assign pix_y       = cy_q[6:0];
   assign pix_colour  = colour_q;
   assign fill_busy   = (state_q == RUN);
   assign fill_done   = (state_q == DONE);

endmodule

// File: rtl/vga_rect_fill_arbiter.sv
// vga_rect_fill_arbiter: shares the VGA adapter plot port between direct CPU
// pixel writes and the rectangle-fill engine. The CPU has priority, but after
// CPU_BURST_MAX consecutive CPU grants during a fill the engine is forced one
// slot. The adapter port is registered: a grant in cycle N plots in N+1.
//
// Ports:
//   clock, reset                         : clock, asynchronous active-high reset
//   cpu_plot_valid/x/y/colour, cpu_plot_ready : CPU write request, comb grant
//   fill_start, fill_x0/y0/w/h/colour    : rectangle fill launch
//   fill_abort                           : (VGA_FILL_ABORT_EN only) stop fill
//   fill_busy, fill_done                 : fill status
//   plot, plot_x, plot_y, plot_colour    : registered adapter port
//
// Optional feature macro: VGA_FILL_ABORT_EN adds the fill_abort input.
module vga_rect_fill_arbiter
   import vga_pkg::*;
#(
   parameter int CPU_BURST_MAX = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpu_plot_valid,
   input  logic [7:0]             cpu_plot_x,
   input  logic [6:0]             cpu_plot_y,
   input  logic [COLOUR_BITS-1:0] cpu_plot_colour,
   output logic                   cpu_plot_ready,
   input  logic                   fill_start,
   input  logic [7:0]             fill_x0,
   input  logic [6:0]             fill_y0,
   input  logic [7:0]             fill_w,
   input  logic [6:0]             fill_h,
   input  logic [COLOUR_BITS-1:0] fill_colour,
`ifdef VGA_FILL_ABORT_EN
   input  logic                   fill_abort,
`endif
   output logic                   fill_busy,
   output logic                   fill_done,
   output logic                   plot,
   output logic [7:0]             plot_x,
   output logic [6:0]             plot_y,
   output logic [COLOUR_BITS-1:0] plot_colour
);

   localparam int BW = $clog2(CPU_BURST_MAX + 1);

   logic          eng_valid, eng_visible, eng_grant;
   logic [7:0]    eng_x;
   logic [6:0]    eng_y;
   colour_t       eng_colour;

   logic [BW-1:0] burst_q, burst_d;
   logic          plot_q, plot_d;
   logic [7:0]    plot_x_q, plot_x_d;
   logic [6:0]    plot_y_q, plot_y_d;
   colour_t       plot_colour_q, plot_colour_d;

   vga_rect_walker u_walker (
      .clock       (clock),
      .reset       (reset),
      .fill_start  (fill_start),
      .fill_x0     (fill_x0),
      .fill_y0     (fill_y0),
      .fill_w      (fill_w),
      .fill_h      (fill_h),
      .fill_colour (fill_colour),
`ifdef VGA_FILL_ABORT_EN
      .fill_abort  (fill_abort),
`endif
      .pix_ready   (eng_grant),
      .pix_valid   (eng_valid),
      .pix_visible (eng_visible),
      .pix_x       (eng_x),
      .pix_y       (eng_y),
      .pix_colour  (eng_colour),
      .fill_busy   (fill_busy),
      .fill_done   (fill_done)
   );

   // CPU wins unless it has used up its burst while a fill is running;
   // eng_valid is exactly "walker in RUN".
   assign cpu_plot_ready = cpu_plot_valid && !(eng_valid && burst_q == BW'(CPU_BURST_MAX));
   assign eng_grant      = eng_valid && !cpu_plot_ready;

   always_comb begin
      // Outside RUN, or on an engine slot, the burst count restarts.
      burst_d       = (eng_valid && cpu_plot_ready) ? burst_q + BW'(1) : '0;

      plot_d        = 1'b0;
      plot_x_d      = plot_x_q;
      plot_y_d      = plot_y_q;
      plot_colour_d = plot_colour_q;
      if (cpu_plot_ready) begin
         plot_d        = 1'b1;
         plot_x_d      = cpu_plot_x;
         plot_y_d      = cpu_plot_y;
         plot_colour_d = cpu_plot_colour;
      end else if (eng_grant && eng_visible) begin
         // Clipped engine pixels burn the slot but leave the port idle.
         plot_d        = 1'b1;
         plot_x_d      = eng_x;
         plot_y_d      = eng_y;
         plot_colour_d = eng_colour;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         burst_q       <= '0;
         plot_q        <= 1'b0;
         plot_x_q      <= '0;
         plot_y_q      <= '0;
         plot_colour_q <= '0;
      end else begin
         burst_q       <= burst_d;
         plot_q        <= plot_d;
         plot_x_q      <= plot_x_d;
         plot_y_q      <= plot_y_d;
         plot_colour_q <= plot_colour_d;
      end
   end

   assign plot        = plot_q;
   assign plot_x      = plot_x_q;
   assign plot_y      = plot_y_q;
   assign plot_colour = plot_colour_q;

endmodule

// File: tb/tb_vga_rect_fill_arbiter.sv
module tb_vga_rect_fill_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_plot_valid = 1'b0;
   logic [7:0] cpu_plot_x = '0;
   logic [6:0] cpu_plot_y = '0;
   logic [8:0] cpu_plot_colour = '0;
   logic       cpu_plot_ready;
   logic       fill_start = 1'b0;
   logic [7:0] fill_x0 = '0;
   logic [6:0] fill_y0 = '0;
   logic [7:0] fill_w = '0;
   logic [6:0] fill_h = '0;
   logic [8:0] fill_colour = '0;
`ifdef VGA_FILL_ABORT_EN
   logic       fill_abort = 1'b0;
   int         abort_at = -1;
`endif
   logic       fill_busy, fill_done, plot;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [8:0] plot_colour;

   vga_rect_fill_arbiter dut (
      .clock           (clock),
      .reset           (reset),
      .cpu_plot_valid  (cpu_plot_valid),
      .cpu_plot_x      (cpu_plot_x),
      .cpu_plot_y      (cpu_plot_y),
      .cpu_plot_colour (cpu_plot_colour),
      .cpu_plot_ready  (cpu_plot_ready),
      .fill_start      (fill_start),
      .fill_x0         (fill_x0),
      .fill_y0         (fill_y0),
      .fill_w          (fill_w),
      .fill_h          (fill_h),
      .fill_colour     (fill_colour),
`ifdef VGA_FILL_ABORT_EN
      .fill_abort      (fill_abort),
`endif
      .fill_busy       (fill_busy),
      .fill_done       (fill_done),
      .plot            (plot),
      .plot_x          (plot_x),
      .plot_y          (plot_y),
      .plot_colour     (plot_colour)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       cv;
      logic [7:0] cx;
      logic [6:0] cy;
      logic [8:0] cc;
      logic       fs;
      logic [7:0] fx;
      logic [6:0] fy;
      logic [7:0] fw;
      logic [6:0] fh;
      logic [8:0] fc;
      logic       rdy;
      logic       pl;
      logic [7:0] px;
      logic [6:0] py;
      logic [8:0] pc;
      logic       busy;
      logic       done;
   } vec_t;

   function automatic vec_t mk(
      input logic cv, input logic [7:0] cx, input logic [6:0] cy, input logic [8:0] cc,
      input logic fs, input logic [7:0] fx, input logic [6:0] fy, input logic [7:0] fw,
      input logic [6:0] fh, input logic [8:0] fc,
      input logic rdy, input logic pl, input logic [7:0] px, input logic [6:0] py,
      input logic [8:0] pc, input logic busy, input logic done);
      vec_t v;
      v.cv = cv; v.cx = cx; v.cy = cy; v.cc = cc;
      v.fs = fs; v.fx = fx; v.fy = fy; v.fw = fw; v.fh = fh; v.fc = fc;
      v.rdy = rdy; v.pl = pl; v.px = px; v.py = py; v.pc = pc;
      v.busy = busy; v.done = done;
      return v;
   endfunction

   // Results of the most recent run_fill
   int         runcnt, done_cnt, done_idx, ready_err;
   logic [7:0] ex_q[$];
   logic [6:0] ey_q[$];

   function automatic logic [7:0] qx(input int i);
      return (i < ex_q.size()) ? ex_q[i] : 8'hFF;
   endfunction
   function automatic logic [6:0] qy(input int i);
      return (i < ey_q.size()) ? ey_q[i] : 7'h7F;
   endfunction

   // Launch a fill, then watch until two cycles after fill_done.
   // Engine plots are recognised by the fill colour (CPU uses 9'h003).
   task automatic run_fill(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] w,
                           input logic [6:0] h, input logic [8:0] col,
                           input logic cpu_hold, input int restart_at);
      runcnt = 0; done_cnt = 0; done_idx = -1; ready_err = 0;
      ex_q.delete(); ey_q.delete();
      @(posedge clock); #1;
      fill_start = 1'b1; fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_colour = col;
      cpu_plot_valid = cpu_hold; cpu_plot_x = 8'd10; cpu_plot_y = 7'd10; cpu_plot_colour = 9'h003;
      for (int k = 0; k < 400; k++) begin
         @(posedge clock); #1;
         fill_start = (k == restart_at);
         if (k == restart_at) begin
            fill_x0 = 8'd0; fill_y0 = 7'd0; fill_w = 8'd50; fill_h = 7'd5;
         end
`ifdef VGA_FILL_ABORT_EN
         fill_abort = (k == abort_at);
`endif
         #1;
         if (fill_busy) begin
            if (cpu_hold && (cpu_plot_ready !== ((runcnt % 5) != 4))) ready_err++;
            runcnt++;
         end
         if (plot && plot_colour == col) begin
            ex_q.push_back(plot_x);
            ey_q.push_back(plot_y);
         end
         if (fill_done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = k;
         end
         if (done_idx >= 0 && k >= done_idx + 2) break;
      end
      fill_start = 1'b0; cpu_plot_valid = 1'b0;
`ifdef VGA_FILL_ABORT_EN
      fill_abort = 1'b0;
`endif
      if (done_idx < 0) chk("done_timeout", 0, 1);
   endtask

   vec_t vec[12];

   initial begin
      // Reset, CPU write in IDLE, then solo fill (2,3) w=3 h=2.
      vec[0]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,0,0,0,0,        0,0);
      vec[1]  = mk(1,5,6,9'h0AA,    0,0,0,0,0,0,          1,0,0,0,0,        0,0);
      vec[2]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,5,6,9'h0AA,   0,0);
      vec[3]  = mk(0,0,0,0,         1,2,3,3,2,9'h1FF,     0,0,5,6,9'h0AA,   0,0);
      vec[4]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,0,5,6,9'h0AA,   1,0);
      vec[5]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,2,3,9'h1FF,   1,0);
      vec[6]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,3,3,9'h1FF,   1,0);
      vec[7]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,4,3,9'h1FF,   1,0);
      vec[8]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,2,4,9'h1FF,   1,0);
      vec[9]  = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,3,4,9'h1FF,   1,0);
      vec[10] = mk(0,0,0,0,         0,0,0,0,0,0,          0,1,4,4,9'h1FF,   0,1);
      vec[11] = mk(0,0,0,0,         0,0,0,0,0,0,          0,0,4,4,9'h1FF,   0,0);

      #12;
      chk("rst_plot",   plot,        0);
      chk("rst_x",      plot_x,      0);
      chk("rst_y",      plot_y,      0);
      chk("rst_col",    plot_colour, 0);
      chk("rst_busy",   fill_busy,   0);
      chk("rst_done",   fill_done,   0);
      #1 reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(posedge clock); #1;
         cpu_plot_valid = vec[i].cv; cpu_plot_x = vec[i].cx; cpu_plot_y = vec[i].cy;
         cpu_plot_colour = vec[i].cc;
         fill_start = vec[i].fs; fill_x0 = vec[i].fx; fill_y0 = vec[i].fy;
         fill_w = vec[i].fw; fill_h = vec[i].fh; fill_colour = vec[i].fc;
         #1;
         chk($sformatf("v%0d_ready", i), cpu_plot_ready, vec[i].rdy);
         chk($sformatf("v%0d_plot",  i), plot,           vec[i].pl);
         chk($sformatf("v%0d_x",     i), plot_x,         vec[i].px);
         chk($sformatf("v%0d_y",     i), plot_y,         vec[i].py);
         chk($sformatf("v%0d_col",   i), plot_colour,    vec[i].pc);
         chk($sformatf("v%0d_busy",  i), fill_busy,      vec[i].busy);
         chk($sformatf("v%0d_done",  i), fill_done,      vec[i].done);
      end
      cpu_plot_valid = 1'b0; fill_start = 1'b0;

      // Clipping at the bottom-right corner
      run_fill(8'd158, 7'd119, 8'd4, 7'd2, 9'h12A, 1'b0, -1);
      chk("clip_run",   runcnt,      8);
      chk("clip_done",  done_cnt,    1);
      chk("clip_n",     ex_q.size(), 2);
      chk("clip_x0",    qx(0),       158);
      chk("clip_y0",    qy(0),       119);
      chk("clip_x1",    qx(1),       159);
      chk("clip_y1",    qy(1),       119);

      // Arbitration: CPU saturating, 4 CPU slots then 1 engine slot
      run_fill(8'd30, 7'd40, 8'd20, 7'd1, 9'h1C0, 1'b1, -1);
      chk("arb_run",    runcnt,      100);
      chk("arb_ready",  ready_err,   0);
      chk("arb_n",      ex_q.size(), 20);
      chk("arb_xfirst", qx(0),       30);
      chk("arb_xlast",  qx(19),      49);
      chk("arb_y",      qy(19),      40);
      chk("arb_done",   done_cnt,    1);

      // Zero-size fill
      run_fill(8'd5, 7'd5, 8'd0, 7'd4, 9'h077, 1'b0, -1);
      chk("zero_didx",  done_idx,    0);
      chk("zero_run",   runcnt,      0);
      chk("zero_n",     ex_q.size(), 0);
      chk("zero_done",  done_cnt,    1);

      // Restart during RUN is ignored
      run_fill(8'd20, 7'd20, 8'd2, 7'd1, 9'h055, 1'b0, 1);
      chk("rs_run",     runcnt,      2);
      chk("rs_n",       ex_q.size(), 2);
      chk("rs_x0",      qx(0),       20);
      chk("rs_x1",      qx(1),       21);
      chk("rs_y1",      qy(1),       20);
      chk("rs_didx",    done_idx,    2);
      chk("rs_done",    done_cnt,    1);

`ifdef VGA_FILL_ABORT_EN
      // Full-screen fill aborted on RUN cycle 7
      abort_at = 7;
      run_fill(8'd0, 7'd0, 8'd160, 7'd120, 9'h0F0, 1'b0, -1);
      abort_at = -1;
      chk("ab_run",     runcnt,      8);
      chk("ab_n",       ex_q.size(), 8);
      chk("ab_xlast",   qx(7),       7);
      chk("ab_ylast",   qy(7),       0);
      chk("ab_done",    done_cnt,    1);
`endif

      // Reset in the middle of a fill
      @(posedge clock); #1;
      fill_start = 1'b1; fill_x0 = 8'd0; fill_y0 = 7'd0; fill_w = 8'd10; fill_h = 7'd10;
      fill_colour = 9'h1AB;
      @(posedge clock); #1;
      fill_start = 1'b0;
      repeat (4) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("mrst_plot",  plot,        0);
      chk("mrst_x",     plot_x,      0);
      chk("mrst_y",     plot_y,      0);
      chk("mrst_col",   plot_colour, 0);
      chk("mrst_busy",  fill_busy,   0);
      chk("mrst_done",  fill_done,   0);
      @(negedge clock);
      reset = 1'b0;
      done_cnt = 0; runcnt = 0; ready_err = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clock); #2;
         if (fill_done) done_cnt++;
         if (fill_busy) runcnt++;
         if (plot) ready_err++;
      end
      chk("mrst_nodone", done_cnt,  0);
      chk("mrst_idle",   runcnt,    0);
      chk("mrst_noplot", ready_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
